// File: rtl/ic_frame_pkg.sv
// Shared definitions for the IceCream debug record framing (decoder now, encoder later).
package ic_frame_pkg;

    typedef enum logic [2:0] {
        IC_MARK = 3'd0,
        IC_HEX  = 3'd1,
        IC_DEC  = 3'd2,
        IC_CHAR = 3'd3,
        IC_STR  = 3'd4
    } ic_fmt_e;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_FMT,
        ST_TAG,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_OUT
    } ic_dec_state_e;

    localparam logic [7:0] IC_SYNC_DEFAULT = 8'hC3;
    localparam logic [7:0] IC_FMT_MAX      = 8'd4;

    function automatic logic [7:0] ic_xor8(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/ic_byte_timeout.sv
// Inter-byte idle counter: expire pulses on the LIMIT-th consecutive enabled cycle.
module ic_byte_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ic_frame_decoder.sv
// Hunts SYNC, parses and checksums IC debug frames, and presents timestamped records.
module ic_frame_decoder
    import ic_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = IC_SYNC_DEFAULT,
    parameter int unsigned MAX_LEN   = 8,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [2:0]             rec_fmt,
    output logic [7:0]             rec_tag,
    output logic [3:0]             rec_len,
    output logic [8*MAX_LEN-1:0]   rec_value,
    output logic [TS_W-1:0]        rec_ts,
    output logic                   err_chk,
    output logic                   err_fmt,
    output logic                   err_len,
    output logic                   err_tmo,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            drop_cnt
);

    ic_dec_state_e   state;
    logic [7:0]      acc;
    logic [3:0]      idx;
    logic [TS_W-1:0] ts_cnt;
    logic            accept;
    logic            parsing;
    logic            tmo;

    assign accept  = in_valid && in_ready;
    assign parsing = state inside {ST_FMT, ST_TAG, ST_LEN, ST_DATA, ST_CHK};

    ic_byte_timeout #(
        .LIMIT(TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept || !parsing),
        .en     (parsing && !accept),
        .expire (tmo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            in_ready  <= 1'b1;
            rec_valid <= 1'b0;
            rec_fmt   <= '0;
            rec_tag   <= '0;
            rec_len   <= '0;
            rec_value <= '0;
            rec_ts    <= '0;
            err_chk   <= 1'b0;
            err_fmt   <= 1'b0;
            err_len   <= 1'b0;
            err_tmo   <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            acc       <= '0;
            idx       <= '0;
            ts_cnt    <= '0;
        end else begin
            ts_cnt  <= ts_cnt + 1'b1;
            err_chk <= 1'b0;
            err_fmt <= 1'b0;
            err_len <= 1'b0;
            err_tmo <= 1'b0;
            // tmo can only fire on a cycle with no accepted byte, so it never races a transition
            if (tmo) begin
                err_tmo <= 1'b1;
                state   <= ST_HUNT;
            end else begin
                case (state)
                    ST_HUNT: if (accept) begin
                        if (in_data == SYNC_BYTE) begin
                            rec_ts    <= ts_cnt;
                            acc       <= '0;
                            rec_value <= '0;
                            state     <= ST_FMT;
                        end else if (drop_cnt != '1) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                    ST_FMT: if (accept) begin
                        if (in_data > IC_FMT_MAX) begin
                            err_fmt <= 1'b1;
                            state   <= ST_HUNT;
                        end else begin
                            rec_fmt <= in_data[2:0];
                            acc     <= ic_xor8(acc, in_data);
                            state   <= ST_TAG;
                        end
                    end
                    ST_TAG: if (accept) begin
                        rec_tag <= in_data;
                        acc     <= ic_xor8(acc, in_data);
                        state   <= ST_LEN;
                    end
                    ST_LEN: if (accept) begin
                        if (in_data > 8'(MAX_LEN)) begin
                            err_len <= 1'b1;
                            state   <= ST_HUNT;
                        end else begin
                            rec_len <= in_data[3:0];
                            acc     <= ic_xor8(acc, in_data);
                            idx     <= '0;
                            state   <= (in_data == 8'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                    ST_DATA: if (accept) begin
                        for (int unsigned i = 0; i < MAX_LEN; i++) begin
                            if (idx == 4'(i)) rec_value[8*i +: 8] <= in_data;
                        end
                        acc <= ic_xor8(acc, in_data);
                        if (idx == rec_len - 4'd1) begin
                            state <= ST_CHK;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    ST_CHK: if (accept) begin
                        if (in_data == acc) begin
                            rec_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= ST_OUT;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_HUNT;
                        end
                    end
                    ST_OUT: if (rec_ready) begin
                        rec_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= ST_HUNT;
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ic_frame_decoder.sv
// Directed plus randomized frame traffic for ic_frame_decoder, checked against a frame-level model.
module tb_ic_frame_decoder;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TS_W    = 32;
    localparam logic [7:0]  SYNC    = 8'hC3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [7:0]           in_data = 8'h00;
    logic                 in_ready;
    logic                 rec_valid;
    logic                 rec_ready = 1'b0;
    logic [2:0]           rec_fmt;
    logic [7:0]           rec_tag;
    logic [3:0]           rec_len;
    logic [8*MAX_LEN-1:0] rec_value;
    logic [TS_W-1:0]      rec_ts;
    logic                 err_chk, err_fmt, err_len, err_tmo;
    logic [15:0]          frame_cnt, drop_cnt;

    ic_frame_decoder #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAX_LEN),
        .TS_W      (TS_W),
        .TIMEOUT   (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_fmt   (rec_fmt),
        .rec_tag   (rec_tag),
        .rec_len   (rec_len),
        .rec_value (rec_value),
        .rec_ts    (rec_ts),
        .err_chk   (err_chk),
        .err_fmt   (err_fmt),
        .err_len   (err_len),
        .err_tmo   (err_tmo),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    logic [31:0] tb_cyc;
    logic [7:0]  frame[$];

    // Cycle count since reset release, i.e. the timestamp a SYNC accepted now should carry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 64'({in_ready, rec_valid, err_chk, err_fmt, err_len, err_tmo}), 64'(6'b100000));
        check({tag, "_rec"}, 64'({rec_fmt, rec_tag, rec_len}), 64'd0);
        check({tag, "_value"}, rec_value, 64'd0);
        check({tag, "_ts"}, 64'(rec_ts), 64'd0);
        check({tag, "_cnts"}, 64'({frame_cnt, drop_cnt}), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        in_valid  = 1'b1;
        in_data   = b;
        rec_ready = 1'($urandom_range(0, 1));
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_wait", 64'(w < 50), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (b == SYNC);
            send_byte(b);
            if (exp_drops < 65535) exp_drops++;
        end
    endtask

    task automatic build(input int fmt, input int tag, input int len, input bit corrupt);
        logic [7:0] x;
        logic [7:0] p;
        frame.delete();
        frame.push_back(SYNC);
        frame.push_back(8'(fmt));
        frame.push_back(8'(tag));
        frame.push_back(8'(len));
        x = 8'(fmt) ^ 8'(tag) ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            frame.push_back(p);
            x ^= p;
        end
        if (corrupt) x ^= 8'(1 << $urandom_range(0, 7));
        frame.push_back(x);
    endtask

    // Outcome is decided from the frame contents alone: bad fmt, bad len, bad checksum or a record.
    task automatic run_frame(input int gap_max, input int hold);
        int          n, ek, last;
        logic [7:0]  x;
        logic [31:0] ts_exp;
        logic [63:0] vexp;
        logic        errs_seen;
        last = frame.size() - 1;
        x = 0;
        for (int i = 1; i < last; i++) x ^= frame[i];
        if (int'(frame[1]) > 4) begin
            n = 2; ek = 2;
        end else if (int'(frame[3]) > int'(MAX_LEN)) begin
            n = 4; ek = 3;
        end else begin
            n = frame.size(); ek = (x == frame[last]) ? 0 : 1;
        end
        vexp = 0;
        if (ek == 0) for (int i = 0; i < int'(frame[3]); i++) vexp |= 64'(frame[4+i]) << (8*i);
        ts_exp = tb_cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            if (i == 0) ts_exp = tb_cyc;
            send_byte(frame[i]);
        end
        if (ek == 0) begin
            exp_frames++;
            rec_ready = 1'b0;
            check("rec_valid_rise", 64'(rec_valid), 64'd1);
            check("errs_quiet", 64'({err_chk, err_fmt, err_len, err_tmo}), 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (p == 1) begin
                    errs_seen = 1'b0;
                    repeat (hold) begin
                        @(posedge clk); #1;
                        errs_seen |= |{err_chk, err_fmt, err_len, err_tmo};
                    end
                    check("no_err_in_out", 64'(errs_seen), 64'd0);
                end
                check("rec_valid_hold", 64'(rec_valid), 64'd1);
                check("in_ready_out", 64'(in_ready), 64'd0);
                check("rec_fmt", 64'(rec_fmt), 64'(frame[1]));
                check("rec_tag", 64'(rec_tag), 64'(frame[2]));
                check("rec_len", 64'(rec_len), 64'(frame[3]));
                check("rec_value", rec_value, vexp);
                check("rec_ts", 64'(rec_ts), 64'(ts_exp));
            end
            rec_ready = 1'b1;
            @(posedge clk); #1;
            rec_ready = 1'b0;
            check("valid_drop", 64'(rec_valid), 64'd0);
            check("in_ready_back", 64'(in_ready), 64'd1);
        end else begin
            check("err_vec", 64'({err_chk, err_fmt, err_len, err_tmo}),
                  (ek == 1) ? 64'h8 : (ek == 2) ? 64'h4 : 64'h2);
            check("no_rec_on_err", 64'(rec_valid), 64'd0);
            @(posedge clk); #1;
            check("err_one_cycle", 64'({err_chk, err_fmt, err_len, err_tmo}), 64'd0);
        end
        check("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    endtask

    initial begin
        int w;
        int fmt, len;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reference frame: 01^05^02^34^12 = 20, value 0x1234, back-to-back ready
        frame = '{8'hC3, 8'h01, 8'h05, 8'h02, 8'h34, 8'h12, 8'h20};
        run_frame(0, 0);

        send_byte(8'h00);
        send_byte(8'hFF);
        exp_drops += 2;
        frame = '{8'hC3, 8'h00, 8'h07, 8'h00, 8'h07};
        run_frame(2, 3);

        frame = '{8'hC3, 8'h01, 8'h05, 8'h02, 8'h34, 8'h12, 8'h21};
        run_frame(0, 0);
        build(2, 9, 4, 0);
        run_frame(1, 1);

        build(5, 1, 1, 0);
        run_frame(0, 0);
        build(1, 1, 9, 0);
        run_frame(0, 0);
        build(4, 8'h33, MAX_LEN, 0);
        run_frame(0, 0);

        build(3, 8'h41, 1, 0);
        run_frame(1, 10);
        build(4, 8'h42, 8, 0);
        run_frame(0, 0);
        build(1, 8'h43, 2, 0);
        run_frame(0, 300);

        // Stall after TAG: err_tmo must appear on exactly the 255th idle cycle
        build(1, 8'h22, 3, 0);
        for (int i = 0; i < 3; i++) send_byte(frame[i]);
        w = 0;
        while (!err_tmo && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        check("tmo_cycles", 64'(w), 64'd255);
        check("tmo_no_rec", 64'(rec_valid), 64'd0);
        @(posedge clk); #1;
        check("tmo_one_cycle", 64'(err_tmo), 64'd0);
        build(0, 8'h23, 0, 0);
        run_frame(0, 0);

        // Reset while a record is pending
        build(2, 8'h55, 5, 0);
        for (int i = 0; i < frame.size(); i++) send_byte(frame[i]);
        check("pre_rst_valid", 64'(rec_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("mid_out");
        exp_frames = 0;
        exp_drops  = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        build(1, 8'h66, 3, 0);
        run_frame(1, 2);

        for (int k = 0; k < 150; k++) begin
            send_garbage($urandom_range(0, 3));
            fmt = ($urandom_range(0, 9) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, 4);
            len = ($urandom_range(0, 9) == 0) ? 9 + $urandom_range(0, 6) : $urandom_range(0, 8);
            build(fmt, $urandom_range(0, 255), len, $urandom_range(0, 5) == 0);
            run_frame(3, $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ic_frame_decoder.md
Name: ic_frame_decoder

Overview:
- Receive-side counterpart of the IceCream debug print path.
- On-chip IC emitters serialize debug records (format, tag, value) into a byte stream. This block hunts frame sync, parses and checksums each frame, timestamps it, and presents one decoded record per valid/ready handshake.
- Consumers are the sim monitor that prints "IC_SV::" lines and the trace RAM logger.
- Sits between the debug byte link (UART/JTAG-FIFO) and the record consumer.

Parameters:
- SYNC_BYTE, 8'hC3: frame start marker.
- MAX_LEN, 8: maximum payload bytes, legal range 1..8; value bus width is 8*MAX_LEN.
- TS_W, 32: timestamp/cycle counter width.
- TIMEOUT, 255: idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available.
- in_data  in  8  stream byte.
- in_ready  out  1  byte accepted when in_valid&&in_ready.
- rec_valid  out  1  decoded record available.
- rec_ready  in  1  consumer accepts record.
- rec_fmt  out  3  0=MARK,1=HEX,2=DEC,3=CHAR,4=STR.
- rec_tag  out  8  variable/source id.
- rec_len  out  4  payload byte count.
- rec_value  out  8*MAX_LEN  payload, little-endian, zero-extended.
- rec_ts  out  TS_W  cycle count when SYNC was accepted.
- err_chk  out  1  one-cycle pulse: checksum mismatch.
- err_fmt  out  1  one-cycle pulse: fmt > 4.
- err_len  out  1  one-cycle pulse: LEN > MAX_LEN.
- err_tmo  out  1  one-cycle pulse: inter-byte timeout.
- frame_cnt  out  16  good records delivered (wraps).
- drop_cnt  out  16  non-sync bytes discarded in HUNT (saturates at 16'hFFFF).

Behaviour:
- Frame format: SYNC, FMT, TAG, LEN, LEN payload bytes, CHK. CHK = XOR of FMT, TAG, LEN and all payload bytes.
- Reset (async assert, sync deassert use):
  - state=HUNT; in_ready=1; rec_valid=0.
  - All rec_* = 0; err_* = 0; counters = 0; timestamp counter = 0.
- Timestamp counter increments every cycle and wraps modulo 2^TS_W.
- States: HUNT, FMT, TAG, LEN, DATA, CHK, OUT.
  - HUNT: a byte equal to SYNC_BYTE latches rec_ts, clears the XOR accumulator and value register, and goes to FMT. Any other byte increments drop_cnt.
  - FMT: fmt > 4 pulses err_fmt and returns to HUNT. Otherwise latch the byte, XOR it into the accumulator, and go to TAG.
  - TAG: latch, XOR, go to LEN.
  - LEN: LEN > MAX_LEN pulses err_len and returns to HUNT. LEN==0 goes directly to CHK (legal for MARK). Otherwise go to DATA with the byte index cleared.
  - DATA: byte i is written to rec_value[8i+7:8i] and XORed. After the LEN-th byte, go to CHK.
  - CHK: if the byte equals the accumulator, go to OUT and assert rec_valid on the next cycle. On mismatch, pulse err_chk, discard the record, and return to HUNT.
  - OUT: in_ready=0. rec_* stay stable while rec_valid && !rec_ready. On handshake: rec_valid drops next cycle, frame_cnt increments, state=HUNT, in_ready=1.
- Latency: CHK accepted at cycle N gives rec_valid=1 at N+1. If rec_ready is high at N+1, a new SYNC can be accepted at N+2.
- in_ready=1 in every state except OUT. Bytes are consumed only on in_valid&&in_ready.
- A SYNC_BYTE value inside FMT..CHK is treated as data. There is no resync mid-frame.
- Timeout applies in states FMT..CHK only:
  - A counter resets on every accepted byte.
  - When it reaches TIMEOUT cycles with no accepted byte, pulse err_tmo and return to HUNT.
  - The timeout is not active in HUNT or OUT.
- Error pulses are mutually exclusive and last exactly one cycle.
- rec_fmt, rec_tag and rec_len registers may change during parsing. Consumers sample them only while rec_valid=1.
- Reset mid-frame or mid-OUT drops the record immediately. There is no residual rec_valid.

Decomposition:
- ic_frame_pkg:
  - fmt enum ic_fmt_e (IC_MARK, IC_HEX, IC_DEC, IC_CHAR, IC_STR).
  - state enum ic_dec_state_e.
  - SYNC default constant.
  - IC_FMT_MAX=4.
  - checksum function ic_xor8.
  - The future ic_frame_encoder shares this package.
- One sub-module: ic_byte_timeout (counter, clear, enable, expire pulse).
- FSM and datapath stay in ic_frame_decoder.

Test Plan:
1. Send C3 01 05 02 34 12 (CHK=01^05^02^34^12=20) with rec_ready=1. Expect rec_valid one cycle after CHK, fmt=1, tag=5, len=2, value=0x1234, rec_ts = counter at SYNC, frame_cnt=1.
2. Send garbage 00 FF then MARK frame C3 00 07 00 07. Expect drop_cnt=2 and a record with fmt=0, tag=7, len=0, value=0.
3. Send the frame from test 1 with CHK=21. Expect one err_chk pulse, no rec_valid, frame_cnt unchanged. A following good frame decodes normally.
4. Send FMT=05, and separately LEN=09. Expect err_fmt and err_len pulses respectively, with the FSM back in HUNT.
5. Hold rec_ready=0 for 10 cycles after a good frame. Expect in_ready=0 and rec_* stable. Release rec_ready: handshake, then in_ready=1 the next cycle and a back-to-back frame is accepted.
6. Stall in_valid for 255 cycles after the TAG byte. Expect an err_tmo pulse and return to HUNT. Also assert rst_n=0 during OUT: rec_valid=0 and all outputs return to their reset values immediately.
